// File: rtl/push_button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: button indices and
// the per-button auto-repeat state encoding.
package push_pkg;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_M = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/push_button_conditioner_debounce_rpt.sv
// One button: two-flop synchroniser, counter debounce, registered press/release
// pulses and the hold-to-auto-repeat state machine.
module button_debounce_rpt
  import push_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_DLY   = 50_000_000,
  parameter int REPEAT_RATE  = 20_000_000,
  parameter int CNT_W        = 26
) (
  input  logic clk_osc,
  input  logic resetn,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_rel
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] rcnt, rcnt_next;
  rpt_state_t       state, state_next;
  logic             mismatch, deb_done, rise, fall, rpt_pulse;

  // The level flips on the edge where the last disagreeing sample is counted,
  // so rise/fall are known combinationally and the pulses land with the level.
  assign mismatch = s2 ^ btn_level;
  assign deb_done = mismatch && (dcnt == DEB_LAST);
  assign rise     = deb_done && !btn_level;
  assign fall     = deb_done && btn_level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes s1 -> s2 a real two-stage chain.
  always_ff @(posedge clk_osc or negedge resetn) begin
    if (!resetn) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      dcnt      <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
      btn_rel   <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      if (!mismatch) begin
        dcnt <= '0;
      end else if (deb_done) begin
        dcnt      <= '0;
        btn_level <= ~btn_level;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      btn_press <= rise | rpt_pulse;
      btn_rel   <= fall;
    end
  end

  always_ff @(posedge clk_osc or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
    end
  end

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    rpt_pulse  = 1'b0;
    if (fall) begin
      state_next = ST_IDLE;
      rcnt_next  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state_next = ST_HOLD;
            rcnt_next  = '0;
          end
        end
        ST_HOLD: begin
          if (!repeat_en) begin
            rcnt_next = '0;
          end else if (rcnt == DLY_LAST) begin
            rpt_pulse  = 1'b1;
            rcnt_next  = '0;
            state_next = ST_RPT;
          end else begin
            rcnt_next = rcnt + 1'b1;
          end
        end
        ST_RPT: begin
          if (!repeat_en) begin
            state_next = ST_HOLD;
            rcnt_next  = '0;
          end else if (rcnt == RATE_LAST) begin
            rpt_pulse = 1'b1;
            rcnt_next = '0;
          end else begin
            rcnt_next = rcnt + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          rcnt_next  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/push_button_conditioner.sv
// Conditions all board push buttons: one independent debounce/repeat channel
// per bit of btn_raw (0=u, 1=d, 2=l, 3=r, 4=m).
module push_button_conditioner
  import push_pkg::*;
#(
  parameter int N_BTN        = BTN_M + 1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_DLY   = 50_000_000,
  parameter int REPEAT_RATE  = 20_000_000,
  parameter int CNT_W        = 26
) (
  input  logic             clk_osc,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_rel
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_debounce_rpt #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_RATE (REPEAT_RATE),
      .CNT_W       (CNT_W)
    ) u_btn (
      .clk_osc  (clk_osc),
      .resetn   (resetn),
      .btn_raw  (btn_raw[i]),
      .repeat_en(repeat_en[i]),
      .btn_level(btn_level[i]),
      .btn_press(btn_press[i]),
      .btn_rel  (btn_rel[i])
    );
  end

endmodule
